// File: rtl/alu_pkg.sv
// Shared constants for the alu scheduler: alu opcodes, scheduler FSM encoding and the
// divide-by-zero predicate used when a result is captured.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  function automatic logic is_div0(input logic [1:0] sel, input logic [7:0] b);
    return (sel == ALU_DIV) && (b == 8'd0);
  endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the pointer, wrapping
// modulo NREQ. The pointer register itself is owned by the caller.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_vld_o
);

  always_comb begin : pick
    int             idx;
    logic [IDW-1:0] idx_w;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    idx_w     = '0;
    if (en_i) begin
      for (int k = 0; k < NREQ; k++) begin
        idx   = (int'(ptr_i) + k) % NREQ;
        idx_w = IDW'(idx);
        if (!gnt_vld_o && req_i[idx_w]) begin
          gnt_vld_o    = 1'b1;
          gnt_o[idx_w] = 1'b1;
          gnt_idx_o    = idx_w;
        end
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered 8-bit alu among NREQ requesters, returning
// each result tagged with its requester ID and a divide-by-zero flag.
//   state   | meaning
//   IDLE    | waiting for any req_valid; arbiter grants combinationally
//   ISSUE   | op registers drive the alu; alu samples at end of cycle
//   CAPTURE | alu_out valid; result (or div0 substitute) captured on the edge
//   RESP    | response held until resp_ready; may grant the next op in the same cycle
module alu_sched
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_sel,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [1:0]        alu_sel,
  input  logic [7:0]        alu_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_err,
  output logic              busy
);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [7:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]      op_sel_q, op_sel_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [7:0]      resp_data_q, resp_data_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;

  logic            arb_en, gnt_vld, div0;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;

  // Reset gates the arbiter so req_ready stays low while rst_n is asserted.
  assign arb_en = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready));
  assign div0   = is_div0(op_sel_q, op_b_q);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;

    if (gnt_vld) begin
      ptr_d    = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
      op_a_d   = req_a[8*int'(gnt_idx) +: 8];
      op_b_d   = req_b[8*int'(gnt_idx) +: 8];
      op_sel_d = req_sel[2*int'(gnt_idx) +: 2];
      op_id_d  = gnt_idx;
    end

    case (state_q)
      ST_IDLE:    if (gnt_vld) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = div0;
        resp_data_d  = div0 ? 8'd0 : alu_out;
        resp_id_d    = op_id_q;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = gnt_vld ? ST_ISSUE : ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      op_id_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign req_ready  = gnt;
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_sel    = op_sel_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: behavioural alu, transaction-level reference model checked every cycle,
// directed literal scenarios followed by randomized traffic.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [7:0]  req_sel;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [1:0]  alu_sel;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
  );

  // The shared alu: one registered result per clock, no reset; div0 returns junk.
  always @(posedge clk) begin
    case (alu_sel)
      ALU_ADD: alu_out <= alu_a + alu_b;
      ALU_SUB: alu_out <= alu_a - alu_b;
      ALU_MUL: alu_out <= alu_a * alu_b;
      default: alu_out <= (alu_b == 8'd0) ? 8'hA5 : alu_a / alu_b;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_alu(input int a, input int b, input int sel,
                                  output int r, output int e);
    e = 0;
    case (sel)
      0:       r = (a + b) % 256;
      1:       r = (a - b + 256) % 256;
      2:       r = (a * b) % 256;
      default: if (b == 0) begin r = 0; e = 1; end else r = a / b;
    endcase
  endfunction

  // Reference model: one op in flight, result visible a fixed number of edges after accept.
  int m_ptr, m_left;
  bit m_pending, m_rv;
  int m_data, m_id, m_err;
  int p_a, p_b, p_sel, p_data, p_id, p_err;
  int g_m, g_c;
  bit acc_m;
  logic [3:0] exp_rdy;

  function automatic int pick();
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic bit can_accept();
    return !m_pending && (!m_rv || resp_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_pending = 0; m_rv = 0; m_left = 0;
    end else begin
      g_m   = pick();
      acc_m = can_accept() && (g_m >= 0);
      if (m_rv && resp_ready) m_rv = 0;
      if (m_pending) begin
        m_left--;
        if (m_left == 0) begin
          m_pending = 0; m_rv = 1;
          m_data = p_data; m_id = p_id; m_err = p_err;
        end
      end
      if (acc_m) begin
        m_ptr     = (g_m + 1) % NREQ;
        m_pending = 1;
        m_left    = 2;
        p_a   = int'(req_a[8*g_m +: 8]);
        p_b   = int'(req_b[8*g_m +: 8]);
        p_sel = int'(req_sel[2*g_m +: 2]);
        p_id  = g_m;
        ref_alu(p_a, p_b, p_sel, p_data, p_err);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      g_c     = pick();
      exp_rdy = (can_accept() && g_c >= 0) ? (4'b0001 << g_c) : 4'b0000;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_pending || m_rv);
      chk("resp_valid", resp_valid, m_rv);
      if (m_rv) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_id", resp_id, m_id);
        chk("resp_err", resp_err, m_err);
      end
      if (m_pending) chk("alu_ops", {alu_a, alu_b, alu_sel}, {p_a[7:0], p_b[7:0], p_sel[1:0]});
    end
  end

  task automatic set_op(input int idx, input int a, input int b, input int sel);
    req_a[8*idx +: 8]   = a[7:0];
    req_b[8*idx +: 8]   = b[7:0];
    req_sel[2*idx +: 2] = sel[1:0];
  endtask

  task automatic wait_grant(input int idx, input string nm);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1;
      else begin @(posedge clk); #1; end
    end
    chk({nm, "_grant"}, got, 1);
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 12 && cyc == 0; i++) begin
      @(negedge clk);
      if (resp_valid) cyc = i;
    end
  endtask

  task automatic do_op(input int idx, input int a, input int b, input int sel,
                       input int exp_d, input int exp_e, input string nm);
    int cyc;
    @(posedge clk); #1;
    set_op(idx, a, b, sel);
    req_valid  = 4'b0001 << idx;
    resp_ready = 1'b1;
    wait_grant(idx, nm);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_resp(cyc);
    chk({nm, "_latency"}, cyc, 3);
    chk({nm, "_data"}, resp_data, exp_d);
    chk({nm, "_err"}, resp_err, exp_e);
    chk({nm, "_id"}, resp_id, idx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_rr[5];
    int gord[5], rord[5];
    int ng, nr, cyc;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; resp_ready = 1'b1;
    #1;
    chk("reset_outputs", {req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_data,
                          resp_id, resp_err, busy}, 64'd0);
    req_valid = 4'hF;
    #1 chk("reset_req_ready", req_ready, 4'b0000);
    req_valid = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    do_op(0, 20, 7, ALU_ADD, 27, 0, "single_add");
    do_op(1, 5, 9, ALU_SUB, 8'hFC, 0, "sub_wrap");
    do_op(3, 16, 17, ALU_MUL, 8'h10, 0, "mul_trunc");
    do_op(2, 200, 7, ALU_DIV, 28, 0, "div_trunc");
    do_op(0, 200, 100, ALU_ADD, 44, 0, "add_wrap");
    do_op(2, 9, 0, ALU_DIV, 0, 1, "div0");
    do_op(2, 9, 3, ALU_DIV, 3, 0, "div_after_div0");

    // Round-robin from a fresh pointer with everyone requesting.
    rst_n = 1'b0; req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    exp_rr = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) set_op(i, 10 + i, i + 1, i);
    @(posedge clk); #1;
    req_valid = 4'hF; resp_ready = 1'b1;
    ng = 0; nr = 0;
    for (int c = 0; c < 60 && nr < 5; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0 && ng < 5) begin
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) gord[ng] = k;
        ng++;
      end
      if (resp_valid && nr < 5) begin rord[nr] = int'(resp_id); nr++; end
      @(posedge clk); #1;
      if (ng >= 5) req_valid = 4'h0;
    end
    chk("rr_grant_count", ng, 5);
    chk("rr_resp_count", nr, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), gord[k], exp_rr[k]);
      chk($sformatf("rr_resp_id%0d", k), rord[k], exp_rr[k]);
    end

    // Backpressure: response held five cycles while req1 waits.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    set_op(0, 50, 3, ALU_SUB);
    req_valid = 4'b0001;
    wait_grant(0, "bp_req0");
    @(posedge clk); #1;
    set_op(1, 6, 7, ALU_MUL);
    req_valid = 4'b0010;
    wait_resp(cyc);
    chk("bp_latency", cyc, 3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold", {resp_valid, resp_data, resp_id, resp_err}, {1'b1, 8'd47, 2'd0, 1'b0});
      chk("bp_no_ready", req_ready, 4'b0000);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_same_cycle_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_resp(cyc);
    chk("bp_req1_latency", cyc, 3);
    chk("bp_req1_data", {resp_data, resp_id, resp_err}, {8'd42, 2'd1, 1'b0});

    // Reset during CAPTURE: everything clears, nothing is returned.
    @(posedge clk); #1;
    set_op(0, 1, 2, ALU_ADD);
    req_valid = 4'b0001;
    wait_grant(0, "rst_req0");
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_data,
                            resp_id, resp_err, busy}, 64'd0);
    req_valid = 4'hF;
    repeat (2) begin
      @(negedge clk);
      chk("rst_held_quiet", {req_ready, resp_valid, busy}, 6'd0);
    end
    #2 rst_n = 1'b1;
    #1 chk("rst_ptr_zero", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'h0;
    repeat (6) @(posedge clk);

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      for (int k = 0; k < NREQ; k++)
        if ($urandom_range(5, 0) == 0) req_b[8*k +: 8] = 8'd0;
      req_sel    = 8'($urandom);
      resp_ready = ($urandom_range(3, 0) != 0);
    end

    @(posedge clk); #1;
    req_valid = 4'h0; resp_ready = 1'b1;
    repeat (8) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
